// File: rtl/router_fifo_pkt_if.sv
// router_fifo_pkt_if: write/read/status bundle of one router output FIFO.
// master drives the write and read requests; slave is the FIFO, which returns data and status.
interface router_fifo_pkt_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                     write_enb;
    logic                     read_enb;
    logic                     lfd_state;
    logic [DATA_W-1:0]        data_in;
    logic [DATA_W-1:0]        data_out;
    logic                     data_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic [$clog2(DEPTH):0]   fill_level;
    logic                     pkt_busy;
    logic                     overflow;
    logic                     underflow;
    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, data_valid, full, empty, almost_full, fill_level, pkt_busy, overflow, underflow
    );
    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, data_valid, full, empty, almost_full, fill_level, pkt_busy, overflow, underflow
    );
endinterface

// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware FIFO for one router output channel.
// Ports: clk, resetn (async active-low), soft_reset (sync flush), bus (router_fifo_pkt_if.slave:
// write_enb/read_enb/lfd_state/data_in in; data_out/data_valid/full/empty/almost_full/fill_level/
// pkt_busy/overflow/underflow out). Each entry carries a header flag above the data bits.
module router_fifo_pkt #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int LEN_LSB  = 2,
    parameter int LEN_W    = 6,
    parameter int AFULL_TH = 14
) (
    input logic              clk,
    input logic              resetn,
    input logic              soft_reset,
    router_fifo_pkt_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [AW:0]       wr_pt_q, wr_pt_d, rd_pt_q, rd_pt_d, fill;
    logic [LEN_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              lfd_q, lfd_d, dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;
    logic              full, empty, wr_acc, rd_acc;
    logic [DATA_W:0]   rd_word;
    assign fill  = wr_pt_q - rd_pt_q;
    assign empty = wr_pt_q == rd_pt_q;
    assign full  = (wr_pt_q[AW] != rd_pt_q[AW]) && (wr_pt_q[AW-1:0] == rd_pt_q[AW-1:0]);
    always_comb begin
        wr_acc  = bus.write_enb && !full;
        rd_acc  = bus.read_enb && !empty;
        rd_word = mem_q[rd_pt_q[AW-1:0]];
        wr_pt_d = soft_reset ? '0 : wr_pt_q + (AW+1)'(wr_acc);
        rd_pt_d = soft_reset ? '0 : rd_pt_q + (AW+1)'(rd_acc);
        lfd_d   = !soft_reset && bus.lfd_state;
        // a header reload covers payload plus the trailing parity byte
        cnt_d   = soft_reset ? '0 :
                  !rd_acc ? cnt_q :
                  rd_word[DATA_W] ? (LEN_W+1)'(rd_word[LEN_LSB +: LEN_W]) + 1'b1 :
                  cnt_q - (LEN_W+1)'(cnt_q != '0);
        // output is held only while a packet is still in flight
        dout_d  = soft_reset ? '0 : rd_acc ? rd_word[DATA_W-1:0] : (cnt_q != '0) ? dout_q : '0;
        dv_d    = !soft_reset && rd_acc;
        ovf_d   = !soft_reset && (ovf_q || (bus.write_enb && full));
        udf_d   = !soft_reset && (udf_q || (bus.read_enb && empty));
    end
    always_ff @(posedge clk)
        if (wr_acc && !soft_reset) mem_q[wr_pt_q[AW-1:0]] <= {lfd_q, bus.data_in};
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_pt_q <= '0;
            rd_pt_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            lfd_q   <= 1'b0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wr_pt_q <= wr_pt_d;
            rd_pt_q <= rd_pt_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            lfd_q   <= lfd_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end
    assign bus.data_out    = dout_q;
    assign bus.data_valid  = dv_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.fill_level  = fill;
    assign bus.almost_full = fill >= (AW+1)'(AFULL_TH);
    assign bus.pkt_busy    = cnt_q != '0;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb_router_fifo_pkt: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_router_fifo_pkt;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic soft_reset = 1'b0;
    router_fifo_pkt_if #(.DATA_W(8), .DEPTH(16)) bus();
    router_fifo_pkt dut (.clk(clk), .resetn(resetn), .soft_reset(soft_reset), .bus(bus));
    typedef struct packed {
        logic [7:0] d;
        logic       b;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] d);
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.lfd_state = lfd;
        bus.data_in   = d;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] d, input logic b);
        exp_t e;
        e.d = d;
        e.b = b;
        sb.push_back(e);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin
                chk("valid_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("data_out", bus.data_out, e.d);
                    chk("pkt_busy", bus.pkt_busy, e.b);
                end
            end
        end
    end
    initial begin
        bus.write_enb = 0;
        bus.read_enb  = 0;
        bus.lfd_state = 0;
        bus.data_in   = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        cyc(1, 0, 0, 8'hAA);
        cyc(1, 0, 0, 8'hBB);
        chk("pre_reset_fill", bus.fill_level, 2);
        #2 resetn = 0;
        #1;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_fill", bus.fill_level, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_data_valid", bus.data_valid, 0);
        chk("rst_almost_full", bus.almost_full, 0);
        bus.write_enb = 0;
        @(posedge clk);
        #1 resetn = 1;
        cyc(0, 0, 1, 8'h00);
        push(8'h0C, 1); cyc(1, 0, 0, 8'h0C);
        push(8'h11, 1); cyc(1, 0, 0, 8'h11);
        push(8'h22, 1); cyc(1, 0, 0, 8'h22);
        push(8'h33, 1); cyc(1, 0, 0, 8'h33);
        push(8'h5A, 0); cyc(1, 0, 0, 8'h5A);
        chk("pkt_fill", bus.fill_level, 5);
        repeat (5) cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("pkt_tail_data_out", bus.data_out, 0);
        chk("pkt_tail_valid", bus.data_valid, 0);
        chk("pkt_tail_busy", bus.pkt_busy, 0);
        cyc(0, 0, 1, 8'h00);
        push(8'h01, 1); cyc(1, 0, 0, 8'h01);
        push(8'h77, 0); cyc(1, 0, 0, 8'h77);
        cyc(0, 1, 0, 8'h00);
        chk("len0_busy", bus.pkt_busy, 1);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("len0_empty", bus.empty, 1);
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h40 + i), 0);
            cyc(1, 0, 0, 8'(8'h40 + i));
            chk("fill_almost_full", bus.almost_full, 32'(i + 1 >= 14));
            chk("fill_full", bus.full, 32'(i == 15));
            chk("fill_level", bus.fill_level, i + 1);
        end
        chk("overflow_before", bus.overflow, 0);
        cyc(1, 0, 0, 8'hFF);
        chk("overflow_set", bus.overflow, 1);
        chk("overflow_fill", bus.fill_level, 16);
        cyc(1, 1, 0, 8'hEE);
        chk("full_rw_fill", bus.fill_level, 15);
        chk("full_rw_full", bus.full, 0);
        repeat (7) cyc(0, 1, 0, 8'h00);
        chk("drain_to_8", bus.fill_level, 8);
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h80 + i), 0);
            cyc(1, 1, 0, 8'(8'h80 + i));
            chk("steady_fill", bus.fill_level, 8);
        end
        repeat (8) cyc(0, 1, 0, 8'h00);
        chk("drained_empty", bus.empty, 1);
        chk("underflow_before", bus.underflow, 0);
        cyc(0, 1, 0, 8'h00);
        chk("underflow_set", bus.underflow, 1);
        chk("underflow_valid", bus.data_valid, 0);
        chk("underflow_empty", bus.empty, 1);
        chk("underflow_fill", bus.fill_level, 0);
        push(8'h99, 0); cyc(1, 0, 0, 8'h99);
        cyc(0, 1, 0, 8'h00);
        chk("after_underflow_valid", bus.data_valid, 1);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 1, 8'h00);
        push(8'h10, 1); cyc(1, 0, 0, 8'h10);
        push(8'hA1, 1); cyc(1, 0, 0, 8'hA1);
        cyc(1, 0, 0, 8'hA2);
        cyc(1, 0, 0, 8'hA3);
        cyc(1, 0, 0, 8'hA4);
        chk("soft_pre_fill", bus.fill_level, 5);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        chk("soft_pre_busy", bus.pkt_busy, 1);
        chk("soft_pre_data_out", bus.data_out, 8'hA1);
        soft_reset = 1;
        cyc(0, 0, 0, 8'h00);
        soft_reset = 0;
        chk("soft_empty", bus.empty, 1);
        chk("soft_busy", bus.pkt_busy, 0);
        chk("soft_data_out", bus.data_out, 0);
        chk("soft_overflow", bus.overflow, 0);
        chk("soft_underflow", bus.underflow, 0);
        chk("soft_fill", bus.fill_level, 0);
        push(8'h55, 0); cyc(1, 0, 0, 8'h55);
        cyc(0, 1, 0, 8'h00);
        repeat (3) cyc(0, 0, 0, 8'h00);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
